// File: rtl/ham_d_if.sv
// ham_d_if: received-word input and branch-metric outputs of the Viterbi branch-metric unit
interface ham_d_if;
    logic        en_brch;
    logic [15:0] data;
    logic [1:0]  hamd_1, hamd_2, hamd_3, hamd_4, hamd_5, hamd_6, hamd_7, hamd_8;
    modport master (output en_brch, data, input hamd_1, hamd_2, hamd_3, hamd_4, hamd_5, hamd_6, hamd_7, hamd_8);
    modport slave  (input en_brch, data, output hamd_1, hamd_2, hamd_3, hamd_4, hamd_5, hamd_6, hamd_7, hamd_8);
endinterface

// File: rtl/ham_d.sv
// ham_d: K=3 rate-1/2 Viterbi branch metrics, one 2-bit symbol of a 16-bit word per enabled cycle
module ham_d (
    input logic   clk,
    input logic   rst,
    ham_d_if.slave bus
);
    // expected {c0,c1} for branch j lives at bits [2j+1:2j]
    localparam logic [15:0] EXP = 16'b10_01_01_10_00_11_11_00;
    logic [1:0]  data_rx_q, data_rx_d, next_rx;
    logic [13:0] sreg_q, sreg_d;
    logic [2:0]  sym_cnt_q, sym_cnt_d;
    logic [1:0]  hamd_q [8];
    logic [1:0]  hamd_d [8];
    logic [1:0]  x;
    always_comb begin
        next_rx   = sym_cnt_q == 3'd0 ? bus.data[15:14] : sreg_q[13:12];
        data_rx_d = !rst ? 2'b00 : bus.en_brch ? next_rx : data_rx_q;
        sreg_d    = !rst ? 14'd0 : !bus.en_brch ? sreg_q :
                    sym_cnt_q == 3'd0 ? bus.data[13:0] : {sreg_q[11:0], 2'b00};
        sym_cnt_d = !rst ? 3'd0 : bus.en_brch ? sym_cnt_q + 3'd1 : sym_cnt_q;
        x         = 2'b00;
        for (int j = 0; j < 8; j++) begin
            x         = next_rx ^ EXP[2*j +: 2];
            hamd_d[j] = !rst ? 2'b00 : bus.en_brch ? {&x, ^x} : hamd_q[j];
        end
    end
    always_ff @(posedge clk) begin
        data_rx_q <= data_rx_d;
        sreg_q    <= sreg_d;
        sym_cnt_q <= sym_cnt_d;
        hamd_q    <= hamd_d;
    end
    assign bus.hamd_1 = hamd_q[0];
    assign bus.hamd_2 = hamd_q[1];
    assign bus.hamd_3 = hamd_q[2];
    assign bus.hamd_4 = hamd_q[3];
    assign bus.hamd_5 = hamd_q[4];
    assign bus.hamd_6 = hamd_q[5];
    assign bus.hamd_7 = hamd_q[6];
    assign bus.hamd_8 = hamd_q[7];
endmodule

// File: tb/tb_ham_d.sv
// tb_ham_d: directed and random checks of ham_d metrics against the distance table
module tb_ham_d;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [15:0] hamd_all;
    logic [15:0] w;
    ham_d_if bus ();
    ham_d dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign hamd_all = {bus.hamd_1, bus.hamd_2, bus.hamd_3, bus.hamd_4,
                       bus.hamd_5, bus.hamd_6, bus.hamd_7, bus.hamd_8};
    function automatic logic [15:0] exp_m(input logic [1:0] rx);
        case (rx)
            2'b00:   return 16'h2855;
            2'b11:   return 16'h8255;
            2'b10:   return 16'h5528;
            default: return 16'h5582;
        endcase
    endfunction
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic run_word(input string tag, input logic [15:0] wd, input int first);
        logic [15:0] ww;
        ww = wd;
        bus.data = wd;
        for (int i = first; i < 8; i++) begin
            step();
            chk(tag, hamd_all, exp_m(ww[15-2*i -: 2]));
            bus.data = 16'($urandom);
        end
    endtask
    initial begin
        bus.en_brch = 1'b1;
        bus.data    = 16'h5A5A;
        step();
        step();
        chk("reset", hamd_all, 16'h0000);
        rst = 1'b1;
        bus.data = 16'hFFFF;
        step();
        chk("first_ffff", hamd_all, 16'h8255);
        run_word("ffff_rest", 16'hFFFF, 1);
        run_word("mixed", 16'b00_11_10_01_00_11_10_01, 0);
        // stall for three edges after symbol 2, then resume with symbol 3
        w = 16'b00_11_10_01_11_00_01_10;
        bus.data = w;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pre_hold", hamd_all, exp_m(w[15-2*i -: 2]));
            bus.data = 16'h0000;
        end
        bus.en_brch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.data = 16'($urandom);
            step();
            chk("hold", hamd_all, 16'h5528);
        end
        bus.en_brch = 1'b1;
        for (int i = 3; i < 8; i++) begin
            step();
            chk("post_hold", hamd_all, exp_m(w[15-2*i -: 2]));
        end
        run_word("zeros", 16'h0000, 0);
        run_word("aaaa", 16'hAAAA, 0);
        w = 16'b11_11_11_11_11_11_00_00;
        bus.data = w;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("pre_rst", hamd_all, exp_m(w[15-2*i -: 2]));
            bus.data = 16'h0000;
        end
        rst = 1'b0;
        step();
        chk("mid_rst", hamd_all, 16'h0000);
        rst = 1'b1;
        run_word("after_rst", 16'b10_01_11_00_10_01_11_00, 0);
        for (int n = 0; n < 1024; n++) run_word("random", 16'($urandom), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
